pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// Hazard and sequencing controller for the 5-stage pipeline. Generates PC/IF-ID stall,
// IF-ID flush and ID/EXE bubble (flush) controls from ID- and EXE-stage register usage,
// taken branches, M-stage exceptions and the multi-cycle mult/div unit (MDU).
// Holds an MDU occupancy FSM/counter and a stall-cycle performance counter.
// PARAMETERS
// MUL_LAT     4   cycles the MDU is busy for mult/multu (>=1)
// DIV_LAT     32  cycles the MDU is busy for div/divu (>=1)
// CNT_W       6   MDU down-counter width; must hold max(MUL_LAT,DIV_LAT)-1
// DELAY_SLOT  0   1 = branch delay slot architected, taken branch never flushes IF-ID
// PORTS
// clk           in   1   pipeline clock, rising edge
// rst           in   1   asynchronous reset, active-high
// Drs_addr      in   5   rs field of ID-stage instruction
// Drt_addr      in   5   rt field of ID-stage instruction
// Drs_use       in   1   ID instruction reads rs in ID/EXE
// Drt_use       in   1   ID instruction reads rt in ID/EXE
// Dmdu_use      in   1   ID instruction touches MDU/hi/lo (mult*,div*,mfhi,mflo,mthi,mtlo)
// Dbranch_taken in   1   branch/jump resolved taken in ID
// Erf_waddr     in   5   EXE-stage destination register
// Erf_wena      in   1   EXE-stage register-file write enable
// Edmem_rena    in   1   EXE-stage instruction is a load
// Emdu_start    in   1   EXE-stage instruction launches a mult/div this cycle
// Emdu_div      in   1   qualifies Emdu_start: 1 = div, 0 = mult
// Mexc          in   1   exception/eret taken in MEM stage
// pc_stall      out  1   hold PC
// fd_stall      out  1   hold IF/ID register
// fd_flush      out  1   clear IF/ID register to nop
// de_flush      out  1   clear ID/EXE register (bubble: all enables 0)
// mdu_busy      out  1   MDU occupied (FSM in MDU_WAIT)
// mdu_abort     out  1   one-cycle abort of in-flight MDU op
// stall_cycles  out  32  count of cycles with pc_stall=1
// BEHAVIOUR
// Reset (async, rst=1): state=RUN, mdu_cnt=0, stall_cycles=0; all 1-bit outputs forced 0.
// FSM: RUN, MDU_WAIT (registered). mdu_busy = (state==MDU_WAIT), no extra latency.
//  RUN: Emdu_start & ~Mexc -> MDU_WAIT, mdu_cnt <= (Emdu_div ? DIV_LAT : MUL_LAT)-1.
//  MDU_WAIT: mdu_cnt decrements each cycle; at mdu_cnt==0 -> RUN next edge.
//   => Emdu_start sampled at edge k gives mdu_busy high for exactly LAT cycles, k+1..k+LAT.
//  Emdu_start in MDU_WAIT is ignored (cannot occur legally; bench flags it).
//  Mexc in any state -> RUN, mdu_cnt<=0 next edge; mdu_abort=Mexc&mdu_busy (combinational).
// Hazard terms (combinational from inputs and current state):
//  lu  = Edmem_rena & Erf_wena & (Erf_waddr!=0) &
//        ((Drs_use & Drs_addr==Erf_waddr) | (Drt_use & Drt_addr==Erf_waddr))
//  mdu = mdu_busy & Dmdu_use
//  br  = Dbranch_taken & (DELAY_SLOT==0)
// Priority (highest first), per cycle:
//  1 Mexc: fd_flush=1, de_flush=1, pc_stall=0, fd_stall=0.
//  2 lu|mdu: pc_stall=1, fd_stall=1, de_flush=1, fd_flush=0 (branch re-resolved next cycle).
//  3 br: fd_flush=1; others 0.
//  4 otherwise all 0.
// stall/flush of the same register never both 1; pc_stall==fd_stall always.
// Last MDU_WAIT cycle (mdu_cnt==0) still stalls a dependent ID instruction; it issues next cycle.
// stall_cycles: +1 on each edge with pc_stall=1; wraps 0xFFFFFFFF -> 0; unaffected by Mexc.
// Register $0 as EXE load destination never causes a stall.
// TESTING
// lw $5 in EXE, ID add uses rs=$5 -> 1 cycle pc_stall/fd_stall/de_flush=1, then clear; stall_cycles +1.
// lw $0 in EXE, ID uses $0; or ID rt=$5 with Drt_use=0 -> no stall.
// div launched (Emdu_start=1,Emdu_div=1) at edge k -> mdu_busy high 32 cycles; mflo held in ID
//   stalls all 32 cycles, issues on cycle k+33; with mult, 4 cycles.
// Dbranch_taken=1 alone -> fd_flush=1 one cycle; with lu same cycle -> stall only, fd_flush=0;
//   DELAY_SLOT=1 -> fd_flush never asserted by branch.
// Mexc during MDU_WAIT (cnt=10) with Dmdu_use=1 -> mdu_abort=1, fd_flush=de_flush=1, stall=0;
//   mdu_busy=0 next cycle.
// rst asserted mid-divide -> outputs 0 immediately; stall_cycles preset 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EXE/MEM usage in, stall/flush controls out.
interface pipe_hazard_ctrl_if;
    logic [4:0]  Drs_addr;
    logic [4:0]  Drt_addr;
    logic        Drs_use;
    logic        Drt_use;
    logic        Dmdu_use;
    logic        Dbranch_taken;
    logic [4:0]  Erf_waddr;
    logic        Erf_wena;
    logic        Edmem_rena;
    logic        Emdu_start;
    logic        Emdu_div;
    logic        Mexc;
    logic        pc_stall;
    logic        fd_stall;
    logic        fd_flush;
    logic        de_flush;
    logic        mdu_busy;
    logic        mdu_abort;
    logic [31:0] stall_cycles;

    modport master (
        output Drs_addr, Drt_addr, Drs_use, Drt_use,
        output Dmdu_use, Dbranch_taken,
        output Erf_waddr, Erf_wena, Edmem_rena,
        output Emdu_start, Emdu_div, Mexc,
        input  pc_stall, fd_stall, fd_flush, de_flush,
        input  mdu_busy, mdu_abort, stall_cycles
    );

    modport slave (
        input  Drs_addr, Drt_addr, Drs_use, Drt_use,
        input  Dmdu_use, Dbranch_taken,
        input  Erf_waddr, Erf_wena, Edmem_rena,
        input  Emdu_start, Emdu_div, Mexc,
        output pc_stall, fd_stall, fd_flush, de_flush,
        output mdu_busy, mdu_abort, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use, MDU occupancy,
// taken-branch and MEM exception sequencing plus a stall counter.
module pipe_hazard_ctrl #(
    parameter int MUL_LAT    = 4,
    parameter int DIV_LAT    = 32,
    parameter int CNT_W      = 6,
    parameter int DELAY_SLOT = 0
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);
    typedef enum logic {RUN, MDU_WAIT} state_t;

    state_t     state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0] stall_q;

    logic busy, lu, mdu, br, hold;
    logic pc_stall_c, fd_flush_c, de_flush_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (hz.Mexc) begin
            state_n = RUN;
            cnt_n   = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (hz.Emdu_start) begin
                        state_n = MDU_WAIT;
                        cnt_n   = hz.Emdu_div ? CNT_W'(DIV_LAT - 1)
                                              : CNT_W'(MUL_LAT - 1);
                    end
                end
                MDU_WAIT: begin
                    // a start here is illegal and deliberately ignored
                    if (cnt == '0) state_n = RUN;
                    else           cnt_n   = cnt - 1'b1;
                end
                default: begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign busy = (state == MDU_WAIT);

    assign lu = hz.Edmem_rena & hz.Erf_wena &
                (hz.Erf_waddr != 5'd0) &
                ((hz.Drs_use & (hz.Drs_addr == hz.Erf_waddr)) |
                 (hz.Drt_use & (hz.Drt_addr == hz.Erf_waddr)));
    assign mdu  = busy & hz.Dmdu_use;
    assign br   = hz.Dbranch_taken & (DELAY_SLOT == 0);
    assign hold = lu | mdu;

    always_comb begin
        pc_stall_c = 1'b0;
        fd_flush_c = 1'b0;
        de_flush_c = 1'b0;
        if (rst) begin
            pc_stall_c = 1'b0;
        end else if (hz.Mexc) begin
            fd_flush_c = 1'b1;
            de_flush_c = 1'b1;
        end else if (hold) begin
            // branch in ID is re-resolved once the stall clears
            pc_stall_c = 1'b1;
            de_flush_c = 1'b1;
        end else if (br) begin
            fd_flush_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            stall_q <= '0;
        else if (pc_stall_c) stall_q <= stall_q + 32'd1;
    end

    assign hz.pc_stall     = pc_stall_c;
    assign hz.fd_stall     = pc_stall_c;
    assign hz.fd_flush     = fd_flush_c;
    assign hz.de_flush     = de_flush_c;
    assign hz.mdu_busy     = busy & ~rst;
    assign hz.mdu_abort    = hz.Mexc & busy & ~rst;
    assign hz.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; a second instance with
// DELAY_SLOT=1 checks that taken branches never flush IF/ID there.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst;

    pipe_hazard_ctrl_if a ();
    pipe_hazard_ctrl_if b ();

    pipe_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (a.slave)
    );

    pipe_hazard_ctrl #(.DELAY_SLOT(1)) dut_ds (
        .clk (clk),
        .rst (rst),
        .hz  (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [5:0]  eo;
        logic [31:0] sc;
        logic        ff2;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    logic [31:0] sc_model = 0;
    bit done = 0;

    // eo = {pc_stall, fd_stall, fd_flush, de_flush, mdu_busy, mdu_abort}
    localparam logic [5:0] IDLE = 6'b000000;
    localparam logic [5:0] STL  = 6'b110100;
    localparam logic [5:0] BRF  = 6'b001000;
    localparam logic [5:0] MSTL = 6'b110110;
    localparam logic [5:0] BSY  = 6'b000010;
    localparam logic [5:0] EXC  = 6'b001100;
    localparam logic [5:0] ABT  = 6'b001111;

    task automatic cyc(
        input string nm,
        input logic [4:0] rs, input logic [4:0] rt,
        input logic rsu, input logic rtu,
        input logic mu, input logic br,
        input logic [4:0] wa, input logic we, input logic ld,
        input logic ms, input logic md, input logic exc,
        input logic r, input logic [5:0] eo, input logic ff2
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        a.Drs_addr = rs;  b.Drs_addr = rs;
        a.Drt_addr = rt;  b.Drt_addr = rt;
        a.Drs_use = rsu;  b.Drs_use = rsu;
        a.Drt_use = rtu;  b.Drt_use = rtu;
        a.Dmdu_use = mu;  b.Dmdu_use = mu;
        a.Dbranch_taken = br; b.Dbranch_taken = br;
        a.Erf_waddr = wa; b.Erf_waddr = wa;
        a.Erf_wena = we;  b.Erf_wena = we;
        a.Edmem_rena = ld; b.Edmem_rena = ld;
        a.Emdu_start = ms; b.Emdu_start = ms;
        a.Emdu_div = md;  b.Emdu_div = md;
        a.Mexc = exc;     b.Mexc = exc;
        if (r) sc_model = 0;
        e.nm  = nm;
        e.eo  = eo;
        e.sc  = sc_model;
        e.ff2 = ff2;
        q.push_back(e);
        if (eo[5]) sc_model = sc_model + 1;
    endtask

    task automatic idle(input string nm, input logic [5:0] eo);
        cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eo, 0);
    endtask

    task automatic mwait(input string nm, input logic mu,
                         input logic [5:0] eo);
        cyc(nm, 0, 0, 0, 0, mu, 0, 0, 0, 0, 0, 0, 0, 0, eo, 0);
    endtask

    task automatic launch(input string nm, input logic md);
        cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, md, 0, 0, IDLE, 0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [5:0] got;
            e = q.pop_front();
            got = {a.pc_stall, a.fd_stall, a.fd_flush,
                   a.de_flush, a.mdu_busy, a.mdu_abort};
            total++;
            if (got !== e.eo) begin
                bad++;
                $display("FAIL %s ctl got=%b want=%b", e.nm, got, e.eo);
            end
            total++;
            if (a.stall_cycles !== e.sc) begin
                bad++;
                $display("FAIL %s stall_cycles got=%0d want=%0d",
                         e.nm, a.stall_cycles, e.sc);
            end
            total++;
            if (b.fd_flush !== e.ff2) begin
                bad++;
                $display("FAIL %s ds_fd_flush got=%b want=%b",
                         e.nm, b.fd_flush, e.ff2);
            end
        end
    end

    initial begin
        rst = 1'b1;
        cyc("rst_hold", 5, 0, 1, 0, 0, 1, 5, 1, 1, 0, 0, 0, 1, IDLE, 0);
        idle("idle", IDLE);
        cyc("lu_rs", 5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, STL, 0);
        cyc("lu_clr", 5, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, IDLE, 0);
        cyc("lu_r0", 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, IDLE, 0);
        cyc("lu_rt_nouse", 0, 5, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, IDLE, 0);
        cyc("lu_nowena", 5, 0, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, IDLE, 0);
        cyc("lu_rt", 0, 5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, STL, 0);
        cyc("br", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, BRF, 0);
        cyc("br_lu", 7, 0, 1, 0, 0, 1, 7, 1, 1, 0, 0, 0, 0, STL, 0);
        cyc("br_again", 7, 0, 1, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, BRF, 0);

        launch("mul_go", 0);
        for (int i = 0; i < 4; i++) mwait("mul_wait", 1, MSTL);
        mwait("mul_issue", 1, IDLE);

        launch("div_go", 1);
        for (int i = 0; i < 32; i++) mwait("div_wait", 1, MSTL);
        mwait("div_issue", 1, IDLE);

        launch("div_go2", 1);
        for (int i = 0; i < 21; i++) mwait("div_busy", 0, BSY);
        cyc("abort", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, ABT, 1);
        mwait("post_abort", 1, IDLE);

        cyc("exc_lu", 5, 0, 1, 0, 0, 1, 5, 1, 1, 0, 0, 1, 0, EXC, 1);
        cyc("exc_start", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, EXC, 1);
        mwait("exc_nostart", 1, IDLE);

        launch("div_go3", 1);
        for (int i = 0; i < 3; i++) mwait("div_busy3", 0, BSY);
        cyc("rst_mid", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 0);
        mwait("post_rst", 1, IDLE);
        cyc("lu_after", 5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, STL, 0);
        idle("end", IDLE);

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end
endmodule
